// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor.
// Adds the operands CHUNK bits per clock, least significant chunk first.
// A registered carry links each chunk to the next, so there is no
// combinational carry path between chunks. Both sides use valid/ready
// handshakes. The block also reports carry-out, signed overflow and zero.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // WIDTH is expected to be a whole multiple of CHUNK.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;     // operand a, shifted right one chunk per RUN cycle
  logic [WIDTH-1:0] b_sh;     // b_eff, shifted the same way
  logic [WIDTH-1:0] res_pos;  // partial result, one chunk written per cycle
  logic             carry;    // carry into the current chunk
  logic [CW-1:0]    k;        // index of the chunk being added

  logic [WIDTH-1:0] b_eff;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;

  // Subtraction adds the one's complement of b. The caller supplies the +1
  // through cin.
  assign b_eff = sub ? ~b : b;

  // Add one chunk. Only the registered carry enters from the previous chunk.
  assign chunk_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};

  // Partial result with the current chunk placed at its final position.
  always_comb begin
    res_next = res_pos;
    res_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_pos   <= '0;
      carry     <= 1'b0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b_eff;
            carry    <= cin;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> CHUNK;
          b_sh    <= b_sh >> CHUNK;
          res_pos <= res_next;
          carry   <= chunk_sum[CHUNK];
          k       <= k + 1'b1;
          if (k == K_LAST) begin
            // In the last chunk, bit CHUNK-1 of the shifted operands is the
            // MSB of the original operands.
            sum       <= res_next;
            cout      <= chunk_sum[CHUNK];
            ovf       <= (a_sh[CHUNK-1] == b_sh[CHUNK-1]) &&
                         (chunk_sum[CHUNK-1] != a_sh[CHUNK-1]);
            zero      <= (res_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors with hand-computed results.
// Covers the default 4-chunk build and a single-chunk (CHUNK=16) build.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] sum16;
  logic        cout16, ovf16, zero16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  serial_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(1'b0), .sub(1'b0), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16),
    .zero(zero16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation for a single edge. Returns at the negedge after the accept edge.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid rises, with a bound.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, cycles, 4);
  endtask

  // Release the result, then confirm the block returned to IDLE with outputs held.
  task automatic handshake(input string tag, input logic [15:0] held);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_hold_sum"}, sum, held);
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez);
    int cyc;
    launch(av, bv, ci, sb);
    check({tag, "_busy"}, in_ready, 0);
    wait_done(tag, cyc);
    check({tag, "_sum"}, sum, es);
    check({tag, "_flags"}, {cout, ovf, zero}, {ec, eo, ez});
    $display("op %s: a=%h b=%h cin=%b sub=%b -> sum=%h c=%b v=%b z=%b lat=%0d",
             tag, av, bv, ci, sb, sum, cout, ovf, zero, cyc);
    handshake(tag, es);
  endtask

  initial begin
    int cyc;
    // Reset state
    #2;
    check("rst_outs", {sum, cout, ovf, zero, out_valid}, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    run_op("add",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("sub",  16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add2", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run, between clock edges
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", {sum, cout, ovf, zero, out_valid}, 0);
    $display("op midrst: sum=%h out_valid=%b", sum, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", in_ready, 1);
    run_op("postrst", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);

    // Backpressure with positive overflow; in_valid toggles while DONE
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done("bp", cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 16'h0100 + 16'(i); b = 16'h0001;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, 16'h8000);
      check("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check("bp_flags", {cout, ovf, zero}, 3'b010);
    $display("op bp: sum=%h c=%b v=%b z=%b", sum, cout, ovf, zero);
    handshake("bp", 16'h8000);
    launch(16'h0010, 16'h0020, 1'b0, 1'b0);
    check("bp_next_accept", in_ready, 0);
    wait_done("bp_next", cyc);
    check("bp_next_sum", sum, 16'h0030);
    $display("op bp_next: sum=%h", sum);
    handshake("bp_next", 16'h0030);

    // Single-chunk build: one cycle from accept to out_valid
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h4321; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    check("c16_busy", {in_ready16, out_valid16}, 2'b00);
    @(negedge clk);
    check("c16_valid", out_valid16, 1);
    check("c16_sum", sum16, 16'h5555);
    check("c16_flags", {cout16, ovf16, zero16}, 3'b000);
    $display("op c16: sum=%h out_valid=%b", sum16, out_valid16);
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    check("c16_idle", {in_ready16, out_valid16}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
